// File: rtl/alu_pkg.sv
// Shared widths, opcodes and FSM states for the
// SPI command slave feeding the 4-bit ALU.
package alu_pkg;

  localparam int ALU_W     = 4;
  localparam int OP_W      = 2;
  localparam int PAYLOAD_W = OP_W + 2 * ALU_W;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_CAPTURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one async SPI pin with
// single-cycle rise/fall strobes in the clk domain.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Shift the pin through the chain; keep one extra delayed copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_alu_cmd_slave.sv
// SPI mode-0 slave: shifts in {op, A, B}, drives the ALU,
// and returns the captured result in the next frame.
module spi_alu_cmd_slave
  import alu_pkg::*;
#(
  parameter int FRAME_BITS  = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [ALU_W-1:0] alu_result,
  output logic             cmd_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT =
    CNT_W'(FRAME_BITS - 1);

  state_e                  state;
  logic [FRAME_BITS-1:0]   tx_sr;
  logic [PAYLOAD_W-1:0]    rx_sr;
  logic [CNT_W-1:0]        bit_cnt;
  logic [ALU_W-1:0]        result_reg;
  logic [SYNC_STAGES-1:0]  mosi_q;
  logic                    mosi_s;
  logic                    sclk_unused;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    cs_lvl;
  logic                    cs_rise;
  logic                    cs_fall;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // cs_n idles high so reset must not fake a falling edge
  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // mosi only needs a level, aligned with the sclk chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // Frame FSM: shift, latch operands, capture result, wait for cs_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      result_reg <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            tx_sr   <= {result_reg,
                        {(FRAME_BITS-ALU_W){1'b0}}};
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            rx_sr   <= {rx_sr[PAYLOAD_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (sclk_fall) begin
            tx_sr <= tx_sr << 1;
          end
          if (sclk_rise && bit_cnt == LAST_BIT) begin
            state <= ST_LATCH;
          end else if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_LATCH: begin
          alu_op    <= rx_sr[PAYLOAD_W-1 -: OP_W];
          alu_a     <= rx_sr[2*ALU_W-1 -: ALU_W];
          alu_b     <= rx_sr[ALU_W-1:0];
          cmd_valid <= 1'b1;
          state     <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          result_reg <= alu_result;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          // level test: the cs_n edge may have passed in LATCH
          if (cs_lvl) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign miso    = busy & tx_sr[FRAME_BITS-1];
  assign miso_oe = ~cs_lvl;

endmodule

// File: tb/tb_spi_alu_cmd_slave.sv
// Scenario bench for spi_alu_cmd_slave with a scoreboard
// of expected MISO read-backs and a behavioural ALU.
module tb_spi_alu_cmd_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_result;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];

  int         cmd_cnt = 0;
  int         err_cnt = 0;
  logic [3:0] cap_a   = '0;
  logic [3:0] cap_b   = '0;
  logic [1:0] cap_op  = '0;
  logic       oe_mid;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_model(
    input logic [1:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a + b;
      default: return a - b;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);

  spi_alu_cmd_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .cmd_valid  (cmd_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (cmd_valid) begin
      cmd_cnt <= cmd_cnt + 1;
      cap_a   <= alu_a;
      cap_b   <= alu_b;
      cap_op  <= alu_op;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    exp_q.delete();
    exp_q.push_back(4'h0);
  endtask

  task automatic send_frame(
    input  logic [9:0] pl,
    input  int         nbits,
    input  bit         chk,
    input  int         post,
    input  int         gap,
    output logic [3:0] rx
  );
    logic [3:0] e;
    rx   = '0;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 10) ? pl[9-i] : i[0];
      tick(4);
      if (i < 4) rx[3-i] = miso;
      if (i == 1) oe_mid = miso_oe;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(post);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(gap);
    if (chk) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL miso_read: got %h, scoreboard empty", rx);
      end else begin
        e = exp_q.pop_front();
        if (rx !== e) begin
          n_fail++;
          $display("FAIL miso_read: got %b expected %b", rx, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [16:0] got;
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    tick(3);
    got = {miso, miso_oe, alu_a, alu_b, alu_op,
           cmd_valid, frame_err, busy, 2'b00};
    n_tests++;
    if (got !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    rst_n = 1'b1;
    tick(3);
    got = {miso, miso_oe, alu_a, alu_b, alu_op,
           cmd_valid, frame_err, busy, 2'b00};
    n_tests++;
    if (got !== 17'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h expected 0", got);
    end
    exp_q.delete();
    exp_q.push_back(4'h0);
  endtask

  task automatic test_add();
    logic [3:0] rx;
    int c0;
    c0 = cmd_cnt;
    send_frame({2'b10, 4'h5, 4'h3}, 10, 1, 4, 4, rx);
    exp_q.push_back(4'b1000);
    n_tests++;
    if (oe_mid !== 1'b1) begin
      n_fail++;
      $display("FAIL miso_oe_mid: got %b expected 1", oe_mid);
    end
    n_tests++;
    if (cmd_cnt - c0 !== 1) begin
      n_fail++;
      $display("FAIL add_cmd_count: got %0d expected 1",
               cmd_cnt - c0);
    end
    n_tests++;
    if ({cap_op, cap_a, cap_b} !== {2'b10, 4'h5, 4'h3} ||
        {alu_op, alu_a, alu_b} !== {2'b10, 4'h5, 4'h3}) begin
      n_fail++;
      $display("FAIL add_operands: got %h/%h expected 253",
               {cap_op, cap_a, cap_b}, {alu_op, alu_a, alu_b});
    end
    n_tests++;
    if ({busy, miso_oe, miso} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_frame_idle: got %b expected 000",
               {busy, miso_oe, miso});
    end
  endtask

  task automatic test_sub_and();
    logic [3:0] rx;
    send_frame({2'b11, 4'h3, 4'h5}, 10, 1, 4, 4, rx);
    exp_q.push_back(4'b1110);
    send_frame({2'b00, 4'hC, 4'hA}, 10, 1, 4, 4, rx);
    exp_q.push_back(4'b1000);
    n_tests++;
    if ({alu_op, alu_a, alu_b} !== {2'b00, 4'hC, 4'hA}) begin
      n_fail++;
      $display("FAIL and_operands: got %h expected 0ca",
               {alu_op, alu_a, alu_b});
    end
  endtask

  task automatic test_abort();
    logic [3:0] rx;
    int c0;
    int e0;
    c0 = cmd_cnt;
    e0 = err_cnt;
    send_frame({2'b10, 4'hF, 4'hF}, 6, 1, 2, 6, rx);
    n_tests++;
    if (err_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL abort_frame_err: got %0d expected 1",
               err_cnt - e0);
    end
    n_tests++;
    if (cmd_cnt - c0 !== 0) begin
      n_fail++;
      $display("FAIL abort_no_cmd: got %0d expected 0",
               cmd_cnt - c0);
    end
    n_tests++;
    if ({alu_op, alu_a, alu_b} !== {2'b00, 4'hC, 4'hA}) begin
      n_fail++;
      $display("FAIL abort_hold: got %h expected 0ca",
               {alu_op, alu_a, alu_b});
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  rx;
    logic [9:0]  pl;
    int c0;
    int e0;
    c0 = cmd_cnt;
    e0 = err_cnt;
    pl = {2'b10, 4'h7, 4'h7};
    cs_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mosi = pl[9-i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    do_reset();
    n_tests++;
    if ({alu_op, alu_a, alu_b, busy} !== 11'h0 ||
        cmd_cnt != c0 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h cmd %0d err %0d expected 0",
               {alu_op, alu_a, alu_b, busy},
               cmd_cnt - c0, err_cnt - e0);
    end
    send_frame({2'b01, 4'h9, 4'h6}, 10, 1, 4, 4, rx);
    exp_q.push_back(4'b1111);
    n_tests++;
    if ({alu_op, alu_a, alu_b} !== {2'b01, 4'h9, 4'h6} ||
        cmd_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL or_after_reset: got %h cmd %0d expected 196",
               {alu_op, alu_a, alu_b}, cmd_cnt - c0);
    end
  endtask

  task automatic test_long_frame();
    logic [3:0] rx;
    int c0;
    int e0;
    c0 = cmd_cnt;
    e0 = err_cnt;
    send_frame({2'b10, 4'h7, 4'h6}, 14, 1, 4, 4, rx);
    exp_q.push_back(alu_model(2'b10, 4'h7, 4'h6));
    n_tests++;
    if (err_cnt != e0 || cmd_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL long_frame_pulses: got err %0d cmd %0d expected 0 1",
               err_cnt - e0, cmd_cnt - c0);
    end
    n_tests++;
    if ({alu_op, alu_a, alu_b} !== {2'b10, 4'h7, 4'h6}) begin
      n_fail++;
      $display("FAIL long_frame_operands: got %h expected 276",
               {alu_op, alu_a, alu_b});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rx;
    logic [9:0] pl;
    int c0;
    do_reset();
    c0 = cmd_cnt;
    for (int k = 0; k < 5; k++) begin
      pl = 10'($urandom_range(0, 1023));
      send_frame(pl, 10, 1, 1, 1, rx);
      exp_q.push_back(alu_model(pl[9:8], pl[7:4], pl[3:0]));
    end
    send_frame(10'h0, 10, 1, 4, 4, rx);
    exp_q.push_back(4'h0);
    n_tests++;
    if (cmd_cnt - c0 != 6) begin
      n_fail++;
      $display("FAIL b2b_cmd_count: got %0d expected 6",
               cmd_cnt - c0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    cs_n   = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    oe_mid = 1'b0;
    test_reset();
    test_add();
    test_sub_and();
    test_abort();
    test_reset_mid();
    test_long_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
